// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner and its debounce stage.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic      found;
    key_code_t code;
    logic      multi;
  } scan_result_t;

  localparam scan_result_t NO_KEY = '{found: 1'b0, code: 4'd0, multi: 1'b0};

  typedef enum logic [1:0] {
    DEB_IDLE,
    DEB_HELD,
    DEB_RETRIG
  } deb_state_e;

  // hits[col][row] = 1 for a pressed intersection; lowest row*4+col wins.
  function automatic scan_result_t eval_frame(input logic [NUM_COLS-1:0][NUM_ROWS-1:0] hits);
    scan_result_t res;
    int unsigned  n;
    res = NO_KEY;
    n   = 0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (hits[c][r]) begin
          if (!res.found) res.code = key_code_t'(r * NUM_COLS + c);
          res.found = 1'b1;
          n++;
        end
      end
    end
    res.multi = (n > 32'd1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-result debounce with commit and release/retrigger sequencing.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter logic [7:0] DEBOUNCE_SCANS = 8'd4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         frame_done_i,
  input  scan_result_t frame_res_i,
  output logic         key_level_o,
  output key_code_t    key_code_o,
  output logic         key_press_o
);

  deb_state_e   state_q, state_d;
  scan_result_t cand_q, cand_d;
  logic [7:0]   stable_q, stable_d;
  key_code_t    code_q, code_d;
  logic         press_q, press_d;
  logic         commit;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    code_d   = code_q;
    press_d  = 1'b0;
    commit   = 1'b0;

    if (frame_done_i) begin
      if (frame_res_i == cand_q) begin
        if (stable_q < DEBOUNCE_SCANS - 8'd1) stable_d = stable_q + 8'd1;
      end else begin
        stable_d = '0;
        cand_d   = frame_res_i;
      end
      commit = (stable_d == DEBOUNCE_SCANS - 8'd1);
    end

    case (state_q)
      DEB_IDLE: begin
        if (commit && cand_d.found) begin
          state_d = DEB_HELD;
          code_d  = cand_d.code;
          press_d = 1'b1;
        end
      end
      DEB_HELD: begin
        if (commit) begin
          if (!cand_d.found)               state_d = DEB_IDLE;
          else if (cand_d.code != code_q)  state_d = DEB_RETRIG;
        end
      end
      // No frame can end during this single cycle, so cand_q still holds the new key.
      DEB_RETRIG: begin
        state_d = DEB_HELD;
        code_d  = cand_q.code;
        press_d = 1'b1;
      end
      default: state_d = DEB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= DEB_IDLE;
      cand_q   <= NO_KEY;
      stable_q <= '0;
      code_q   <= '0;
      press_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      code_q   <= code_d;
      press_q  <= press_d;
    end
  end

  assign key_level_o = (state_q == DEB_HELD);
  assign key_code_o  = code_q;
  assign key_press_o = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row sync, column scan, frame accumulation.
// Define KEYPAD_GHOST_REJECT_EN to treat multi-key frames as no key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_CYCLES    = 16'd250,
  parameter logic [7:0]  DEBOUNCE_SCANS = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_level,
  output logic [3:0] key_code,
  output logic       key_press
);

  logic [3:0]                          sync1_q, sync2_q;
  logic [1:0]                          col_idx_q, col_idx_d;
  logic [15:0]                         cyc_cnt_q, cyc_cnt_d;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0]   hits_q, hits_d;
  logic                                frame_done_q, frame_done_d;
  logic                                sample_now;
  scan_result_t                        raw_res, frame_res;

  always_comb begin
    sample_now   = (cyc_cnt_q == SCAN_CYCLES - 16'd1);
    cyc_cnt_d    = sample_now ? '0 : cyc_cnt_q + 16'd1;
    col_idx_d    = sample_now ? col_idx_q + 2'd1 : col_idx_q;
    hits_d       = hits_q;
    frame_done_d = 1'b0;
    // Each column slot is overwritten once per frame, so no explicit clear is needed.
    if (sample_now) begin
      hits_d[col_idx_q] = ~sync2_q;
      frame_done_d      = (col_idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      col_idx_q    <= '0;
      cyc_cnt_q    <= '0;
      hits_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= row_in;
      sync2_q      <= sync1_q;
      col_idx_q    <= col_idx_d;
      cyc_cnt_q    <= cyc_cnt_d;
      hits_q       <= hits_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    raw_res = eval_frame(hits_q);
`ifdef KEYPAD_GHOST_REJECT_EN
    frame_res = raw_res.multi ? NO_KEY : raw_res;
`else
    frame_res = raw_res;
`endif
  end

  assign col_out = ~(4'b0001 << col_idx_q);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_i       (clk),
    .rst_ni      (rst),
    .frame_done_i(frame_done_q),
    .frame_res_i (frame_res),
    .key_level_o (key_level),
    .key_code_o  (key_code),
    .key_press_o (key_press)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-level reference, per-cycle compare.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int D  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic       key_level;
  logic [3:0] key_code;
  logic       key_press;

  keypad_scanner #(
    .SCAN_CYCLES   (16'd4),
    .DEBOUNCE_SCANS(8'd3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_level(key_level),
    .key_code (key_code),
    .key_press(key_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int press_total = 0;

  logic [15:0] keys_down = '0;
  bit          open_all  = 1'b0;

  // reference model state (frame-level view)
  int          k;
  logic [3:0]  h1, h2;
  logic [15:0] m_pm;
  bit          last_found, last_multi;
  int          last_code, run;
  logic        m_level, m_press, retrig;
  logic [3:0]  m_code, retrig_code, m_col;
  bit          eval_due;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_eval();
    bit f, mu;
    int code;
    f    = (m_pm != 16'd0);
    mu   = ($countones(m_pm) > 1);
    code = 0;
    for (int i = 15; i >= 0; i--) if (m_pm[i]) code = i;
`ifdef KEYPAD_GHOST_REJECT_EN
    if (mu) begin f = 1'b0; mu = 1'b0; code = 0; end
`endif
    if (f == last_found && mu == last_multi && code == last_code) run++;
    else begin
      run = 1; last_found = f; last_multi = mu; last_code = code;
    end
    if (run >= D) begin
      if (!f && m_level) m_level = 1'b0;
      else if (f && !m_level) begin
        m_level = 1'b1; m_code = 4'(code); m_press = 1'b1;
      end else if (f && m_level && 4'(code) != m_code) begin
        m_level = 1'b0; retrig = 1'b1; retrig_code = 4'(code);
      end
    end
  endtask

  task automatic model_edge(input logic rst_v, input logic [3:0] rv);
    int c;
    if (!rst_v) begin
      k = 0; h1 = 4'hF; h2 = 4'hF; m_pm = '0;
      last_found = 1'b0; last_multi = 1'b0; last_code = 0; run = 1;
      m_level = 1'b0; m_code = '0; m_press = 1'b0; retrig = 1'b0; retrig_code = '0;
      eval_due = 1'b0; m_col = 4'hE;
      return;
    end
    k++;
    m_press = 1'b0;
    if (retrig) begin
      m_level = 1'b1; m_code = retrig_code; m_press = 1'b1; retrig = 1'b0;
    end
    if (eval_due) begin
      model_eval();
      eval_due = 1'b0;
    end
    if (k % SC == 0) begin
      c = ((k - 1) / SC) % 4;
      for (int r = 0; r < 4; r++) m_pm[r*4 + c] = ~h2[r];
      if (c == 3) eval_due = 1'b1;
    end
    h2 = h1;
    h1 = rv;
    m_col = 4'hF ^ (4'b0001 << ((k / SC) % 4));
  endtask

  task automatic cycle();
    logic [3:0] rv;
    rv = 4'hF;
    if (!open_all)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys_down[r*4 + c] && !col_out[c]) rv[r] = 1'b0;
    row_in = rv;
    @(posedge clk);
    model_edge(rst, rv);
    @(negedge clk);
    check("col_out",   col_out,   m_col);
    check("key_level", key_level, m_level);
    check("key_code",  key_code,  m_code);
    check("key_press", key_press, m_press);
    if (key_press === 1'b1) press_total++;
  endtask

  task automatic wait_level(input logic want, input int limit, output int n);
    n = 0;
    while (key_level !== want && n < limit) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_cols [16];
    int n, p0, zeros, drops;
    bit done;

    for (int i = 0; i < 16; i++) exp_cols[i] = 4'hF ^ (4'b0001 << (i / 4));

    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle();
    check("rst_col_out",   col_out,   4'b1110);
    check("rst_key_level", key_level, 1'b0);
    check("rst_key_code",  key_code,  4'd0);
    check("rst_key_press", key_press, 1'b0);
    rst = 1'b1;

    // idle column sequence
    check("idle_col_0", col_out, exp_cols[0]);
    for (int i = 1; i < 16; i++) begin
      cycle();
      check("idle_col_seq", col_out, exp_cols[i]);
    end
    repeat (33) cycle();
    check("idle_no_press", press_total, 0);

    // key 6 press latency
    keys_down = 16'h0040;
    p0 = press_total;
    wait_level(1'b1, 200, n);
    check("k6_latency_in_range", (n >= 48 && n <= 67), 1);
    check("k6_latency_exact", n, 49);
    check("k6_code", key_code, 4'd6);
    check("k6_press_on_rise", key_press, 1'b1);
    repeat (48) cycle();
    check("k6_single_press", press_total - p0, 1);

    // bounce, then clean release
    p0 = press_total;
    drops = 0;
    for (int i = 0; i < 48; i++) begin
      if (i % 5 == 0) keys_down[6] = ~keys_down[6];
      cycle();
      if (key_level !== 1'b1) drops++;
    end
    check("bounce_level_held", drops, 0);
    keys_down = '0;
    wait_level(1'b0, 200, n);
    check("release_latency", (n <= 67), 1);
    check("bounce_no_press", press_total - p0, 0);

    // key 6 then directly key 9
    keys_down = 16'h0040;
    wait_level(1'b1, 200, n);
    check("k6_again", key_code, 4'd6);
    repeat (20) cycle();
    keys_down = 16'h0200;
    wait_level(1'b0, 200, n);
    zeros = 0;
    done = 1'b0;
    while (!done && zeros < 10) begin
      cycle();
      zeros++;
      if (key_level === 1'b1) done = 1'b1;
    end
    check("retrig_low_cycles", zeros, 1);
    check("retrig_code", key_code, 4'd9);
    check("retrig_press", key_press, 1'b1);

    // ghost pair 3 + 12
    keys_down = '0;
    wait_level(1'b0, 200, n);
    repeat (32) cycle();
    p0 = press_total;
    keys_down = 16'h1008;
    repeat (96) cycle();
`ifdef KEYPAD_GHOST_REJECT_EN
    check("ghost_level", key_level, 1'b0);
    check("ghost_no_press", press_total - p0, 0);
`else
    check("ghost_level", key_level, 1'b1);
    check("ghost_code", key_code, 4'd3);
`endif

    // mid-frame reset with key 6 committed
    keys_down = '0;
    wait_level(1'b0, 200, n);
    keys_down = 16'h0040;
    wait_level(1'b1, 200, n);
    check("pre_reset_code", key_code, 4'd6);
    n = 0;
    while (col_out !== 4'b1101 && n < 20) begin cycle(); n++; end
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("mid_rst_col_out",   col_out,   4'b1110);
    check("mid_rst_key_level", key_level, 1'b0);
    check("mid_rst_key_code",  key_code,  4'd0);
    check("mid_rst_key_press", key_press, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("restart_col0", col_out, 4'b1110);
    end
    cycle();
    check("restart_col1", col_out, 4'b1101);

    // randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      case ($urandom_range(3, 0))
        0: keys_down = '0;
        1: keys_down = 16'h0001 << $urandom_range(15, 0);
        2: keys_down = (16'h0001 << $urandom_range(15, 0)) | (16'h0001 << $urandom_range(15, 0));
        default: ;
      endcase
      n = $urandom_range(80, 8);
      for (int i = 0; i < n; i++) begin
        open_all = ($urandom_range(7, 0) == 0);
        cycle();
      end
      open_all = 1'b0;
      if ($urandom_range(9, 0) == 0) begin
        rst = 1'b0;
        cycle();
        rst = 1'b1;
      end
    end
    keys_down = '0;
    repeat (80) cycle();
    check("final_released", key_level, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
